// File: rtl/gate_test_sequencer.sv
// Deterministic stimulus/check sequencer for the 4-in/3-out AND-gate datapath.
// Walks all 16 input vectors, samples e/f/g after a settle window and tallies mismatches.
module gate_test_sequencer #(
   parameter int unsigned SETTLE = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic       a,
   output logic       b,
   output logic       c,
   output logic       d,
   input  logic       e,
   input  logic       f,
   input  logic       g,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [4:0] err_count,
   output logic [3:0] fail_vec,
   output logic       fail_valid
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_APPLY,
      S_SAMPLE,
      S_NEXT,
      S_DONE
   } state_t;

   localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);
   localparam logic [4:0] ERR_MAX   = 5'd16;

   state_t     state_q, state_d;
   logic [3:0] vec_q, vec_d;
   logic [3:0] cnt_q, cnt_d;
   logic [4:0] err_q, err_d;
   logic [3:0] fvec_q, fvec_d;
   logic       fvld_q, fvld_d;
   logic       pass_q, pass_d;
   logic       done_q, done_d;
   logic       mismatch;

   // Golden model of the gate: {e, f, g} for input vector {a, b, c, d}.
   function automatic logic [2:0] golden(input logic [3:0] v);
      golden = {v[3] & v[2], v[1] & v[0], &v};
   endfunction

   assign mismatch = ({e, f, g} != golden(vec_q));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         vec_q   <= '0;
         cnt_q   <= '0;
         err_q   <= '0;
         fvec_q  <= '0;
         fvld_q  <= 1'b0;
         pass_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         fvec_q  <= fvec_d;
         fvld_q  <= fvld_d;
         pass_q  <= pass_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      fvec_d  = fvec_q;
      fvld_d  = fvld_q;
      pass_d  = pass_q;
      done_d  = 1'b0;

      unique case (state_q)
         S_IDLE, S_DONE: begin
            // A new run wipes the previous results in the same edge it starts.
            if (start) begin
               state_d = S_APPLY;
               vec_d   = '0;
               cnt_d   = '0;
               err_d   = '0;
               fvec_d  = '0;
               fvld_d  = 1'b0;
               pass_d  = 1'b0;
            end
         end
         S_APPLY: begin
            if (cnt_q == SETTLE_M1) begin
               state_d = S_SAMPLE;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         S_SAMPLE: begin
            state_d = S_NEXT;
            if (mismatch) begin
               if (err_q != ERR_MAX) begin
                  err_d = err_q + 5'd1;
               end
               if (!fvld_q) begin
                  fvec_d = vec_q;
                  fvld_d = 1'b1;
               end
            end
         end
         S_NEXT: begin
            if (vec_q == 4'hF) begin
               state_d = S_DONE;
               done_d  = 1'b1;
               pass_d  = (err_q == 5'd0);
            end else begin
               state_d = S_APPLY;
               vec_d   = vec_q + 4'd1;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign {a, b, c, d} = vec_q;
   assign busy         = (state_q == S_APPLY) || (state_q == S_SAMPLE) || (state_q == S_NEXT);
   assign done         = done_q;
   assign pass         = pass_q;
   assign err_count    = err_q;
   assign fail_vec     = fvec_q;
   assign fail_valid   = fvld_q;

endmodule

// File: doc/gate_test_sequencer.md
# gate_test_sequencer

Self-checking stimulus controller for the 4-input/3-output AND-gate datapath (inputs a, b, c, d; outputs e, f, g). On a start pulse it drives all 16 input combinations into the gate under test in ascending order. For each combination it waits a programmable settle time, then samples e/f/g and compares them against the golden model. It reports a mismatch count, the first failing vector and a pass flag, replacing free-running toggle stimulus with a deterministic, board-usable check.

## Interface
- SETTLE, default 2: number of cycles each vector is held before sampling; legal range 1..15.
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to begin a run; honoured only in IDLE or DONE
- a, b, c, d  output  1 each  stimulus to gate under test; {a,b,c,d} = vec, a is MSB
- e, f, g  input  1 each  gate-under-test outputs
- busy  output  1  high from APPLY entry until DONE entry
- done  output  1  one-cycle pulse on DONE entry
- pass  output  1  valid after done; 1 when err_count == 0
- err_count  output  5  number of vectors with any mismatch, 0..16
- fail_vec  output  4  first mismatching vector; valid when fail_valid = 1
- fail_valid  output  1  set on first mismatch of a run

## Operation
- Golden model: exp_e = a&b, exp_f = c&d, exp_g = a&b&c&d.
- States:
  - IDLE: outputs idle.
  - APPLY: vector driven; settle counter runs 0..SETTLE-1.
  - SAMPLE: one cycle; compare on the edge leaving it.
  - NEXT: one cycle.
  - DONE: results held.
- Transitions:
  - IDLE/DONE --start--> APPLY. On this transition: vec=0, err_count=0, fail_valid=0, fail_vec=0, pass=0.
  - APPLY --(cnt==SETTLE-1)--> SAMPLE.
  - SAMPLE --> NEXT.
  - NEXT --(vec==15)--> DONE.
  - NEXT --(vec<15)--> APPLY, with vec+1 and cnt=0.
  - DONE stays in DONE until start.
- Compare, on the edge leaving SAMPLE:
  - mismatch = any of e/f/g differs from expected.
  - On mismatch, err_count increments by 1. It counts vectors, not bits; maximum 16, no wrap.
  - On the first mismatch only: fail_vec=vec and fail_valid=1.
- pass is registered on DONE entry as (err_count_final == 0), and held until the next start.
- start is ignored while busy; no restart and no queued restart.
- vec (and therefore a..d) holds its value through APPLY, SAMPLE and NEXT. It changes only on NEXT->APPLY or on a run start. In DONE it remains 15.

## Timing
- Reset (rst=1 at a rising edge) values: state=IDLE; a=b=c=d=0; busy=0; done=0; pass=0; err_count=0; fail_vec=0; fail_valid=0.
- Reset mid-run aborts immediately to the reset values. No done pulse is produced, and previous results are lost.
- Each vector takes SETTLE + 2 cycles. A full run is 16×(SETTLE+2) cycles from APPLY entry to DONE entry; with the default this is 64 cycles.
- Start seen at edge T puts the FSM in APPLY with vec=0 at T. busy rises in the cycle after T.
- done is high for exactly the first cycle in DONE, which is the same cycle busy drops. pass, err_count and fail_* are stable in that cycle.
- Sampling point: e/f/g are registered at the edge leaving SAMPLE. The gate under test therefore sees each vector for SETTLE+1 full cycles before sampling.
- start coincident with rst: rst wins.
- start asserted in the DONE cycle where done=1: a new run begins next edge and results are cleared.

## Test plan
- Correct combinational model of the gate, SETTLE=2, start pulse → done after 64 cycles; pass=1, err_count=0, fail_valid=0; a..d step 0000..1111, each held 4 cycles.
- g stuck-at-0 → only vector 15 fails: err_count=1, fail_vec=4'hF, fail_valid=1, pass=0.
- e stuck-at-1 → every vector with a&b=0 fails: err_count=12, fail_vec=0, pass=0.
- start pulsed repeatedly during busy → run length unchanged (64 cycles), a single done pulse, results identical to the clean run.
- rst asserted at vector 7 mid-APPLY → next cycle all outputs at reset values, state IDLE; a subsequent start runs a full clean 64-cycle pass.
- SETTLE=1 and SETTLE=15 with a correct model → run lengths 48 and 272 cycles; pass=1. Then a back-to-back start in the done cycle clears results and restarts at vector 0.
